// File: rtl/lcd_timing_gen.sv
// LCD timing master: free-running H/V scan counters with an IDLE/RUN/DRAIN
// controller, registered pixel-side strobes (DEN, X, Y, FRAME_START) and
// panel-side HSYNC/VSYNC/DE delayed to line up with the pixel generator.
module lcd_timing_gen #(
  parameter int LCD_WIDTH  = 480,
  parameter int LCD_HEIGHT = 272,
  parameter int H_SYNC     = 4,
  parameter int H_BP       = 43,
  parameter int H_FP       = 8,
  parameter int V_SYNC     = 4,
  parameter int V_BP       = 12,
  parameter int V_FP       = 8,
  parameter bit SYNC_POL   = 1'b0,
  parameter int PIPE_DLY   = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  output logic        den_o,
  output logic [10:0] x_o,
  output logic [10:0] y_o,
  output logic        frame_start_o,
  output logic        lcd_hsync_o,
  output logic        lcd_vsync_o,
  output logic        lcd_de_o
);

  localparam logic [10:0] H_LAST    = 11'(H_SYNC + H_BP + LCD_WIDTH + H_FP - 1);
  localparam logic [10:0] V_LAST    = 11'(V_SYNC + V_BP + LCD_HEIGHT + V_FP - 1);
  localparam logic [10:0] H_SYNC_W  = 11'(H_SYNC);
  localparam logic [10:0] V_SYNC_W  = 11'(V_SYNC);
  localparam logic [10:0] H_ACT_BEG = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_ACT_END = 11'(H_SYNC + H_BP + LCD_WIDTH);
  localparam logic [10:0] V_ACT_BEG = 11'(V_SYNC + V_BP);
  localparam logic [10:0] V_ACT_END = 11'(V_SYNC + V_BP + LCD_HEIGHT);
  localparam logic        SYNC_OFF  = !SYNC_POL;
  localparam logic [2:0]  PIPE_IDLE = {1'b0, SYNC_OFF, SYNC_OFF};

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

  state_t      state_q, state_d;
  logic [10:0] h_q, h_d, v_q, v_d;
  logic [10:0] x_q, x_d, y_q, y_d;
  logic        den_q, den_d, fs_q, fs_d, hs_q, hs_d, vs_q, vs_d;
  logic        line_end, frame_end, running_d, h_act, v_act;
  logic [2:0]  pipe_in;

  // Controller and scan counters: next state and next (h,v).
  always_comb begin
    state_d   = state_q;
    h_d       = h_q;
    v_d       = v_q;
    line_end  = (h_q == H_LAST);
    frame_end = line_end && (v_q == V_LAST);
    case (state_q)
      ST_IDLE: begin
        h_d = '0;
        v_d = '0;
        if (enable_i) state_d = ST_RUN;
      end
      default: begin
        if (line_end) begin
          h_d = '0;
          v_d = (v_q == V_LAST) ? 11'd0 : v_q + 11'd1;
        end else begin
          h_d = h_q + 11'd1;
        end
        // A frame that was asked to stop while draining ends here even if
        // enable comes back on the very last clock; restart goes via IDLE.
        if (frame_end)
          state_d = (state_q == ST_DRAIN || !enable_i) ? ST_IDLE : ST_RUN;
        else
          state_d = enable_i ? ST_RUN : ST_DRAIN;
      end
    endcase
  end

  // Decode the outputs from the next (h,v) so they register alongside it.
  always_comb begin
    running_d = (state_d != ST_IDLE);
    h_act     = (h_d >= H_ACT_BEG) && (h_d < H_ACT_END);
    v_act     = (v_d >= V_ACT_BEG) && (v_d < V_ACT_END);
    den_d     = running_d && h_act && v_act;
    x_d       = den_d ? (h_d - H_ACT_BEG) : 11'd0;
    y_d       = den_d ? (v_d - V_ACT_BEG) : 11'd0;
    fs_d      = running_d && (h_d == 11'd0) && (v_d == 11'd0);
    hs_d      = (running_d && (h_d < H_SYNC_W)) ? SYNC_POL : SYNC_OFF;
    vs_d      = (running_d && (v_d < V_SYNC_W)) ? SYNC_POL : SYNC_OFF;
  end

  // State, counters and registered timing outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      h_q     <= '0;
      v_q     <= '0;
      den_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      fs_q    <= 1'b0;
      hs_q    <= SYNC_OFF;
      vs_q    <= SYNC_OFF;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      den_q   <= den_d;
      x_q     <= x_d;
      y_q     <= y_d;
      fs_q    <= fs_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
    end
  end

  assign den_o         = den_q;
  assign x_o           = x_q;
  assign y_o           = y_q;
  assign frame_start_o = fs_q;
  assign pipe_in       = {den_q, hs_q, vs_q};

  // Panel-side delay line keeps DE/HSYNC/VSYNC aligned with returned RGB.
  generate
    if (PIPE_DLY == 0) begin : g_nodly
      assign {lcd_de_o, lcd_hsync_o, lcd_vsync_o} = pipe_in;
    end else begin : g_dly
      logic [2:0] dly_q [PIPE_DLY];

      // Shift register; every stage resets to the inactive panel levels.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          for (int i = 0; i < PIPE_DLY; i++) dly_q[i] <= PIPE_IDLE;
        end else begin
          dly_q[0] <= pipe_in;
          for (int i = 1; i < PIPE_DLY; i++) dly_q[i] <= dly_q[i-1];
        end
      end

      assign {lcd_de_o, lcd_hsync_o, lcd_vsync_o} = dly_q[PIPE_DLY-1];
    end
  endgenerate

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen: three configurations (a small active-low setup
// with a 2-stage panel delay, the tiny active-high PIPE_DLY=0 setup, and the
// full-size defaults) run side by side against a frame-position model.
module tb_lcd_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  always #5 clk = ~clk;

  // Config index 0 = A, 1 = B, 2 = C (defaults)
  localparam int P_W   [3] = '{10, 4, 480};
  localparam int P_H   [3] = '{6, 2, 272};
  localparam int P_HS  [3] = '{2, 1, 4};
  localparam int P_HBP [3] = '{3, 1, 43};
  localparam int P_HFP [3] = '{2, 1, 8};
  localparam int P_VS  [3] = '{2, 1, 4};
  localparam int P_VBP [3] = '{1, 1, 12};
  localparam int P_VFP [3] = '{2, 1, 8};
  localparam bit P_POL [3] = '{1'b0, 1'b1, 1'b0};
  localparam int P_DLY [3] = '{2, 0, 1};

  logic        den_a, fs_a, hs_a, vs_a, de_a;
  logic        den_b, fs_b, hs_b, vs_b, de_b;
  logic        den_c, fs_c, hs_c, vs_c, de_c;
  logic [10:0] x_a, y_a, x_b, y_b, x_c, y_c;

  lcd_timing_gen #(.LCD_WIDTH(10), .LCD_HEIGHT(6), .H_SYNC(2), .H_BP(3), .H_FP(2),
                   .V_SYNC(2), .V_BP(1), .V_FP(2), .SYNC_POL(1'b0), .PIPE_DLY(2)) u_a (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .den_o(den_a), .x_o(x_a), .y_o(y_a),
    .frame_start_o(fs_a), .lcd_hsync_o(hs_a), .lcd_vsync_o(vs_a), .lcd_de_o(de_a));

  lcd_timing_gen #(.LCD_WIDTH(4), .LCD_HEIGHT(2), .H_SYNC(1), .H_BP(1), .H_FP(1),
                   .V_SYNC(1), .V_BP(1), .V_FP(1), .SYNC_POL(1'b1), .PIPE_DLY(0)) u_b (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .den_o(den_b), .x_o(x_b), .y_o(y_b),
    .frame_start_o(fs_b), .lcd_hsync_o(hs_b), .lcd_vsync_o(vs_b), .lcd_de_o(de_b));

  lcd_timing_gen u_c (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .den_o(den_c), .x_o(x_c), .y_o(y_c),
    .frame_start_o(fs_c), .lcd_hsync_o(hs_c), .lcd_vsync_o(vs_c), .lcd_de_o(de_c));

  wire [26:0] act_w [3];
  assign act_w[0] = {den_a, x_a, y_a, fs_a, de_a, hs_a, vs_a};
  assign act_w[1] = {den_b, x_b, y_b, fs_b, de_b, hs_b, vs_b};
  assign act_w[2] = {den_c, x_c, y_c, fs_c, de_c, hs_c, vs_c};

  int vectors    = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- model: position within frame + running flag ----------
  bit         m_run   [3];
  bit         m_drain [3];
  int         m_t     [3];
  logic [2:0] m_hist  [3][8];   // {de,hs,vs}, index k = k clocks ago

  function automatic int htot(input int i);
    return P_HS[i] + P_HBP[i] + P_W[i] + P_HFP[i];
  endfunction
  function automatic int vtot(input int i);
    return P_VS[i] + P_VBP[i] + P_H[i] + P_VFP[i];
  endfunction

  // {den, x, y, frame_start} for the current model position
  function automatic logic [23:0] core_now(input int i);
    int h, v, hb, vb;
    logic d;
    h  = m_t[i] % htot(i);
    v  = m_t[i] / htot(i);
    hb = P_HS[i] + P_HBP[i];
    vb = P_VS[i] + P_VBP[i];
    d  = m_run[i] && h >= hb && h < hb + P_W[i] && v >= vb && v < vb + P_H[i];
    return {d, d ? 11'(h - hb) : 11'd0, d ? 11'(v - vb) : 11'd0, m_run[i] && m_t[i] == 0};
  endfunction

  // Undelayed {de, hs, vs} panel levels
  function automatic logic [2:0] panel_now(input int i);
    logic [23:0] c;
    int h, v;
    c = core_now(i);
    h = m_t[i] % htot(i);
    v = m_t[i] / htot(i);
    return {c[23],
            (m_run[i] && h < P_HS[i]) ? P_POL[i] : !P_POL[i],
            (m_run[i] && v < P_VS[i]) ? P_POL[i] : !P_POL[i]};
  endfunction

  function automatic logic [26:0] expect_vec(input int i);
    return {core_now(i), m_hist[i][P_DLY[i]]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_run[i] = 0; m_drain[i] = 0; m_t[i] = 0;
      for (int k = 0; k < 8; k++) m_hist[i][k] = {1'b0, !P_POL[i], !P_POL[i]};
    end
  endtask

  task automatic model_step(input int i, input logic e);
    int ft;
    ft = htot(i) * vtot(i);
    if (!m_run[i]) begin
      if (e) begin m_run[i] = 1; m_t[i] = 0; m_drain[i] = 0; end
    end else if (m_t[i] == ft - 1) begin
      // Frame finished: stop if enable was low on this or the previous clock
      if (m_drain[i] || !e) m_run[i] = 0;
      m_t[i] = 0; m_drain[i] = 0;
    end else begin
      m_t[i]++;
      m_drain[i] = !e;
    end
    for (int k = 7; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
    m_hist[i][0] = panel_now(i);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else for (int i = 0; i < 3; i++) model_step(i, en);
  end

  // Every-cycle comparison of all three DUTs against the model
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      logic [26:0] e;
      e = expect_vec(i);
      vectors++;
      if (act_w[i] !== e) begin
        miscompares++;
        $display("FAIL cycle cfg%0d t=%0d run=%0d: got %h expected %h",
                 i, m_t[i], m_run[i], act_w[i], e);
      end
    end
  end

  // ---------------- directed stimulus with literal expectations -----------
  initial begin
    int a_den, a_vs, a_fs, b_den, b_hs, b_first, b_fs, b_n, c_hs, c_first, cnt;
    logic [10:0] b_x [4];
    logic [10:0] c_x, c_y;
    a_den = 0; a_vs = 0; a_fs = -1; b_den = 0; b_hs = 0; b_first = -1; b_fs = -1;
    b_n = 0; c_hs = 0; c_first = -1; c_x = '1; c_y = '1;
    for (int k = 0; k < 4; k++) b_x[k] = '1;

    repeat (3) @(negedge clk);
    chk("reset_vec_a", 32'(act_w[0]), 32'd3);
    chk("reset_vec_b", 32'(act_w[1]), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_fs_a", 32'(fs_a), 32'd0);
    en = 1'b1;

    for (int k = 0; k <= 8610; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("first_fs_a", 32'(fs_a), 32'd1);
        chk("first_fs_b", 32'(fs_b), 32'd1);
        chk("first_fs_c", 32'(fs_c), 32'd1);
      end
      if (k < 187) begin
        if (den_a) a_den++;
        if (!vs_a) a_vs++;
      end
      if (k > 0 && fs_a && a_fs < 0) a_fs = k;
      if (k < 35) begin
        if (den_b) begin
          b_den++;
          if (b_first < 0) b_first = k;
          if (b_n < 4) begin b_x[b_n] = x_b; b_n++; end
        end
        if (hs_b) b_hs++;
      end
      if (k > 0 && fs_b && b_fs < 0) b_fs = k;
      if (k < 535 && !hs_c) c_hs++;
      if (den_c && c_first < 0) begin c_first = k; c_x = x_c; c_y = y_c; end
      if (k == 8607) chk("c_de_before", 32'(de_c), 32'd0);
      if (k == 8608) chk("c_de_after", 32'(de_c), 32'd1);
    end
    chk("a_den_per_frame", 32'(a_den), 32'd60);
    chk("a_vsync_low", 32'(a_vs), 32'd34);
    chk("a_frame_period", 32'(a_fs), 32'd187);
    chk("b_den_per_frame", 32'(b_den), 32'd8);
    chk("b_hsync_high", 32'(b_hs), 32'd5);
    chk("b_first_den", 32'(b_first), 32'd16);
    for (int k = 0; k < 4; k++) chk($sformatf("b_x%0d", k), 32'(b_x[k]), 32'(k));
    chk("b_frame_period", 32'(b_fs), 32'd35);
    chk("c_hsync_low_line0", 32'(c_hs), 32'd4);
    chk("c_first_den", 32'(c_first), 32'd8607);
    chk("c_first_xy", 32'({c_x, c_y}), 32'd0);

    // Brief enable glitch inside a frame: model expects no timing change
    @(negedge clk); en = 1'b0;
    repeat (3) @(negedge clk);
    en = 1'b1;
    repeat (300) @(negedge clk);

    // Drop enable: A and B finish their frame and go quiet
    en = 1'b0;
    repeat (200) @(negedge clk);
    cnt = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      cnt += int'(fs_a) + int'(fs_b) + int'(den_a) + int'(den_b);
    end
    chk("idle_quiet", 32'(cnt), 32'd0);
    en = 1'b1;
    @(negedge clk);
    chk("restart_fs_a", 32'(fs_a), 32'd1);
    chk("restart_fs_b", 32'(fs_b), 32'd1);

    // Asynchronous reset between clock edges
    repeat (50) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_a", 32'(act_w[0]), 32'd3);
    chk("async_rst_b", 32'(act_w[1]), 32'd0);
    chk("async_rst_c", 32'(act_w[2]), 32'd3);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_fs_a", 32'(fs_a), 32'd1);
    chk("post_rst_fs_c", 32'(fs_c), 32'd1);
    repeat (400) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
